// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures the high time of a 50 Hz servo pulse and
// decodes it back to an angle, flagging malformed pulses and loss of signal.
module servo_pwm_decoder #(
  parameter int MIN_PULSE = 6000,
  parameter int STEP      = 133,
  parameter int MAX_ANGLE = 180,
  parameter int MIN_VALID = 3000,
  parameter int MAX_VALID = 36000,
  parameter int TIMEOUT   = 480000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [7:0]  angle,
  output logic [18:0] pulse_width,
  output logic        angle_valid,
  output logic        frame_error,
  output logic        signal_lost
);

  localparam int CW   = 19;
  localparam int HALF = STEP / 2;

  typedef enum logic [2:0] {
    ARM,
    WAIT_RISE,
    HIGH,
    DIV,
    DONE
  } state_t;

  state_t          state_q;
  logic            s1_q, pwm_s_q, pwm_s_dly_q;
  logic [1:0]      settle_q;
  logic [CW-1:0]   width_q;
  logic [CW-1:0]   rem_q;
  logic [7:0]      quot_q;
  logic [2:0]      bit_q;
  logic [7:0]      angle_q;
  logic [CW-1:0]   pw_q;
  logic            valid_q, err_q, lost_q;
  logic [CW-1:0]   to_cnt_q;

  logic            rise, fall;
  logic [CW-1:0]   divisor;
  logic            take_bit;
  logic [CW-1:0]   rem_d;
  logic [7:0]      quot_d;
  logic [CW-1:0]   to_cnt_d;

  // Offset so that truncating division rounds to the nearest degree.
  function automatic logic [CW-1:0] div_offset(input logic [CW-1:0] w);
    if (w >= CW'(MIN_PULSE)) return w - CW'(MIN_PULSE) + CW'(HALF);
    return '0;
  endfunction

  function automatic logic [7:0] sat_angle(input logic [7:0] q);
    return (q > 8'(MAX_ANGLE)) ? 8'(MAX_ANGLE) : q;
  endfunction

  assign rise = pwm_s_q & ~pwm_s_dly_q;
  assign fall = ~pwm_s_q & pwm_s_dly_q;

  always_comb begin
    divisor  = CW'(STEP) << bit_q;
    take_bit = (rem_q >= divisor);
    rem_d    = take_bit ? (rem_q - divisor) : rem_q;
    quot_d   = quot_q | (take_bit ? (8'd1 << bit_q) : 8'd0);
    to_cnt_d = (to_cnt_q >= CW'(TIMEOUT)) ? CW'(TIMEOUT) : (to_cnt_q + 1'b1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARM;
      s1_q        <= 1'b0;
      pwm_s_q     <= 1'b0;
      pwm_s_dly_q <= 1'b0;
      settle_q    <= 2'd0;
      width_q     <= '0;
      rem_q       <= '0;
      quot_q      <= 8'd0;
      bit_q       <= 3'd0;
      angle_q     <= 8'd0;
      pw_q        <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      lost_q      <= 1'b1;
      to_cnt_q    <= '0;
    end else begin
      s1_q        <= pwm_in;
      pwm_s_q     <= s1_q;
      pwm_s_dly_q <= pwm_s_q;
      // pwm_s only reflects the pin once the synchronizer has refilled after reset.
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      to_cnt_q    <= to_cnt_d;
      if (to_cnt_d == CW'(TIMEOUT)) lost_q <= 1'b1;

      case (state_q)
        ARM: begin
          if (settle_q == 2'd2 && !pwm_s_q) state_q <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            width_q <= CW'(1);
            state_q <= HIGH;
          end
        end
        HIGH: begin
          if (pwm_s_q) begin
            width_q <= width_q + 1'b1;
            if (width_q == CW'(MAX_VALID)) begin
              err_q   <= 1'b1;
              state_q <= ARM;
            end
          end else if (fall) begin
            if (width_q < CW'(MIN_VALID)) begin
              err_q   <= 1'b1;
              state_q <= WAIT_RISE;
            end else begin
              rem_q   <= div_offset(width_q);
              quot_q  <= 8'd0;
              bit_q   <= 3'd7;
              state_q <= DIV;
            end
          end
        end
        DIV: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          bit_q  <= bit_q - 3'd1;
          if (bit_q == 3'd0) begin
            angle_q  <= sat_angle(quot_d);
            pw_q     <= width_q;
            valid_q  <= 1'b1;
            to_cnt_q <= '0;
            lost_q   <= 1'b0;
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= WAIT_RISE;
        end
        default: begin
          state_q <= ARM;
        end
      endcase
    end
  end

  assign angle       = angle_q;
  assign pulse_width = pw_q;
  assign angle_valid = valid_q;
  assign frame_error = err_q;
  assign signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder: a pulse-level model checked every cycle plus
// directed pulses with hand-computed angles, latencies and boundaries.
`timescale 1ns/1ps
module tb_servo_pwm_decoder;

  // Scaled timing keeps the run short; all expectations follow these values.
  localparam int MIN_PULSE = 600;
  localparam int STEP      = 13;
  localparam int MAX_ANGLE = 180;
  localparam int MIN_VALID = 300;
  localparam int MAX_VALID = 3600;
  localparam int TIMEOUT   = 6000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pwm_in = 1'b0;
  logic [7:0]  angle;
  logic [18:0] pulse_width;
  logic        angle_valid, frame_error, signal_lost;

  int n_checks = 0;
  int n_fail   = 0;

  servo_pwm_decoder #(
    .MIN_PULSE(MIN_PULSE), .STEP(STEP), .MAX_ANGLE(MAX_ANGLE),
    .MIN_VALID(MIN_VALID), .MAX_VALID(MAX_VALID), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .angle(angle), .pulse_width(pulse_width),
    .angle_valid(angle_valid), .frame_error(frame_error),
    .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  function automatic int ref_angle(input int w);
    int d, a;
    d = (w >= MIN_PULSE) ? (w - MIN_PULSE + STEP / 2) : 0;
    a = d / STEP;
    return (a > MAX_ANGLE) ? MAX_ANGLE : a;
  endfunction

  // Pulse-level model: cycle n is the interval after posedge n.
  int  cyc = 0;
  bit  model_live = 0;
  bit  m_s1, m_s, m_sd;
  int  m_settle;
  bit  m_track, m_need_low;
  int  m_run, m_busy_until;
  int  ev_valid_at = -1, ev_err_at = -1, ev_angle, ev_pw;
  int  e_angle, e_pw, e_tcnt;
  bit  e_valid, e_err, e_lost;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      model_live = 1;
      m_s1 = 0; m_s = 0; m_sd = 0; m_settle = 0;
      m_track = 0; m_need_low = 1; m_run = 0; m_busy_until = -1;
      ev_valid_at = -1; ev_err_at = -1;
      e_angle = 0; e_pw = 0; e_valid = 0; e_err = 0; e_lost = 1; e_tcnt = 0;
    end else begin
      m_sd = m_s; m_s = m_s1; m_s1 = pwm_in;
      if (m_settle < 2) m_settle++;
      e_valid = (cyc == ev_valid_at);
      e_err   = (cyc == ev_err_at);
      if (e_valid) begin
        e_angle = ev_angle; e_pw = ev_pw; e_tcnt = 0; e_lost = 0;
      end else begin
        if (e_tcnt < TIMEOUT) e_tcnt++;
        if (e_tcnt == TIMEOUT) e_lost = 1;
      end
      if (m_track) begin
        if (m_s) begin
          m_run++;
          if (m_run == MAX_VALID + 1) begin
            ev_err_at = cyc + 1; m_track = 0; m_need_low = 1;
          end
        end else if (m_run < MIN_VALID) begin
          ev_err_at = cyc + 1; m_track = 0;
        end else begin
          ev_valid_at = cyc + 9; ev_angle = ref_angle(m_run); ev_pw = m_run;
          m_busy_until = cyc + 9; m_track = 0;
        end
      end else if (m_need_low) begin
        if (m_settle == 2 && !m_s) m_need_low = 0;
      end else if (cyc > m_busy_until && m_s && !m_sd) begin
        m_track = 1; m_run = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      n_checks++;
      if (angle !== 8'(e_angle) || pulse_width !== 19'(e_pw) || angle_valid !== e_valid ||
          frame_error !== e_err || signal_lost !== e_lost) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL model cyc=%0d got angle=%0d pw=%0d valid=%b err=%b lost=%b, required angle=%0d pw=%0d valid=%b err=%b lost=%b",
                   cyc, angle, pulse_width, angle_valid, frame_error, signal_lost,
                   e_angle, e_pw, e_valid, e_err, e_lost);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic watch(input int maxc, output int n, output bit gv, output bit ge);
    n = 0; gv = 0; ge = 0;
    while (n < maxc && !gv && !ge) begin
      @(negedge clk);
      n++;
      gv = angle_valid;
      ge = frame_error;
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_angle"}, int'(angle), 0);
    chk({tag, "_pw"}, int'(pulse_width), 0);
    chk({tag, "_valid"}, int'(angle_valid), 0);
    chk({tag, "_err"}, int'(frame_error), 0);
    chk({tag, "_lost"}, int'(signal_lost), 1);
  endtask

  task automatic expect_quiet(input string tag);
    int n; bit gv, ge;
    watch(30, n, gv, ge);
    chk({tag, "_no_strobe"}, int'(gv | ge), 0);
  endtask

  // Pin high for exactly w clocks; exp_lat counts negedges from the pin fall.
  task automatic pulse_expect(input int w, input bit is_err, input int exp_angle, input int exp_lat);
    int n; bit gv, ge;
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (w) @(negedge clk);
    pwm_in = 1'b0;
    watch(20, n, gv, ge);
    if (is_err) begin
      chk($sformatf("w%0d_err_lat", w), ge ? n : -1, exp_lat);
      chk($sformatf("w%0d_no_valid", w), int'(gv), 0);
    end else begin
      chk($sformatf("w%0d_valid_lat", w), gv ? n : -1, exp_lat);
      chk($sformatf("w%0d_pw", w), int'(pulse_width), w);
    end
    chk($sformatf("w%0d_angle", w), int'(angle), exp_angle);
    repeat (30) @(negedge clk);
  endtask

  initial begin
    int n, t;
    bit gv, ge;
    reset = 1'b1; pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    chk_reset_values("reset");
    reset = 1'b0;
    repeat (20) @(negedge clk);

    pulse_expect(1770, 0, 90, 11);
    chk("lost_cleared", int'(signal_lost), 0);
    pulse_expect(600, 0, 0, 11);
    pulse_expect(2940, 0, 180, 11);
    pulse_expect(500, 0, 0, 11);
    pulse_expect(3100, 0, 180, 11);
    pulse_expect(1776, 0, 90, 11);
    pulse_expect(1777, 0, 91, 11);
    pulse_expect(299, 1, 91, 3);
    pulse_expect(100, 1, 91, 3);
    pulse_expect(300, 0, 0, 11);
    pulse_expect(3600, 0, 180, 11);
    pulse_expect(3601, 1, 180, 2);

    // Pin stuck high: error at count MAX_VALID+1, trailing fall is silent.
    @(negedge clk);
    pwm_in = 1'b1;
    watch(MAX_VALID + 10, n, gv, ge);
    chk("long_err_lat", ge ? n : -1, MAX_VALID + 3);
    repeat (4000 - n) @(negedge clk);
    pwm_in = 1'b0;
    expect_quiet("long_tail");
    pulse_expect(1770, 0, 90, 11);

    // Second rise while the first pulse is still being divided is skipped.
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (1777) @(negedge clk);
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    pwm_in = 1'b1;
    watch(20, n, gv, ge);
    chk("early_rise_valid_lat", gv ? n : -1, 8);
    chk("early_rise_angle", int'(angle), 91);
    repeat (1000 - n) @(negedge clk);
    pwm_in = 1'b0;
    expect_quiet("early_rise");

    // Pin high across reset release: the partial pulse is not measured.
    @(negedge clk);
    reset = 1'b1; pwm_in = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_values("reset_pin_high");
    reset = 1'b0;
    repeat (1000) @(negedge clk);
    pwm_in = 1'b0;
    expect_quiet("partial");
    for (int i = 0; i < 3; i++) begin
      pulse_expect(1200, 0, 46, 11);
      repeat (1170) @(negedge clk);
    end

    // Loss of signal exactly TIMEOUT cycles after the last decode.
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (2940) @(negedge clk);
    pwm_in = 1'b0;
    watch(20, n, gv, ge);
    chk("to_valid_lat", gv ? n : -1, 11);
    chk("to_lost_at_valid", int'(signal_lost), 0);
    t = 0;
    while (!signal_lost && t < TIMEOUT + 20) begin
      @(negedge clk);
      t++;
    end
    chk("timeout_lat", t, TIMEOUT);

    // Reset in the middle of a pulse abandons it silently.
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (500) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_values("reset_mid_high");
    reset = 1'b0;
    repeat (500) @(negedge clk);
    pwm_in = 1'b0;
    expect_quiet("mid_high");
    pulse_expect(1777, 0, 91, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
